// File: rtl/branch_pkg.sv
// -----------------------------------------------------------------------------
// branch_pkg
// Shared definitions for the branch resolution unit:
//   brOp_e    : branch opcode encodings carried on br_op (6 and 7 are illegal)
//   PHT_INIT  : reset value of every prediction counter (weakly not-taken)
//   satUpdate : 2-bit saturating counter step toward the resolved outcome
// -----------------------------------------------------------------------------
package branch_pkg;

   typedef enum logic [2:0] {
      BR_BEQ  = 3'd0,
      BR_BNE  = 3'd1,
      BR_BLEZ = 3'd2,
      BR_BGTZ = 3'd3,
      BR_BLTZ = 3'd4,
      BR_BGEZ = 3'd5
   } brOp_e;

   localparam logic [1:0] PHT_INIT = 2'b01;

   // Move one step toward the outcome, sticking at 2'b00 and 2'b11.
   function automatic logic [1:0] satUpdate(input logic [1:0] ctr, input logic isTaken);
      logic [1:0] nxt;
      nxt = ctr;
      if (isTaken && (ctr != 2'b11)) begin
         nxt = ctr + 2'b01;
      end else if (!isTaken && (ctr != 2'b00)) begin
         nxt = ctr - 2'b01;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/branch_resolve_unit_pht.sv
// -----------------------------------------------------------------------------
// branch_pht
// Pattern history table: DEPTH x 2-bit saturating counters.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset (all counters -> PHT_INIT)
//   rdIdx      : combinational read index
//   rdTaken    : prediction for rdIdx (counter MSB), pre-update value
//   wrEn       : apply one saturating step at wrIdx on this edge
//   wrIdx      : counter to update
//   wrTaken    : resolved outcome driving the step direction
// The read port reflects the registered array only, so a read and a write to
// the same counter in one cycle returns the old value.
// -----------------------------------------------------------------------------
module branch_pht
   import branch_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int IDX_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [IDX_W-1:0] rdIdx,
   output logic             rdTaken,
   input  logic             wrEn,
   input  logic [IDX_W-1:0] wrIdx,
   input  logic             wrTaken
);

   logic [1:0] ctr [DEPTH];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            ctr[i] <= PHT_INIT;
         end
      end else if (wrEn) begin
         ctr[wrIdx] <= satUpdate(ctr[wrIdx], wrTaken);
      end
   end

   assign rdTaken = ctr[rdIdx][1];

endmodule

// File: rtl/branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// branch_resolve_unit
// Two-stage branch resolver with a 2-bit-counter predictor.
//   S1 holds the accepted branch and the prediction read at accept time; the
//   condition and target are evaluated from S1 and registered into S2, which
//   drives the outputs.
// Ports:
//   clk, rst_n           : clock, synchronous active-low reset
//   in_valid / in_ready  : branch input handshake
//   pc_plus4, offset     : branch address + 4, signed word offset
//   rs_val, rt_val       : register operands
//   br_op                : 0 BEQ, 1 BNE, 2 BLEZ, 3 BGTZ, 4 BLTZ, 5 BGEZ, 6-7 illegal
//   out_valid / out_ready: result handshake
//   taken, target, next_pc, pred_taken, mispredict, illegal : result fields
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; the producer holds valid and data until then, and ready never depends
// on the same side's valid. in_ready = !s1Valid || S2 free, so in_ready reacts
// to out_ready but never to in_valid. Outputs stay frozen while
// out_valid && !out_ready.
// OFFSET_W must be <= WIDTH-2; PHT_DEPTH must be a power of two >= 2.
// -----------------------------------------------------------------------------
module branch_resolve_unit
   import branch_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int OFFSET_W  = 16,
   parameter int PHT_DEPTH = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [WIDTH-1:0]    pc_plus4,
   input  logic [OFFSET_W-1:0] offset,
   input  logic [WIDTH-1:0]    rs_val,
   input  logic [WIDTH-1:0]    rt_val,
   input  logic [2:0]          br_op,
   output logic                out_valid,
   input  logic                out_ready,
   output logic                taken,
   output logic [WIDTH-1:0]    target,
   output logic [WIDTH-1:0]    next_pc,
   output logic                pred_taken,
   output logic                mispredict,
   output logic                illegal
);

   localparam int IDX_W = $clog2(PHT_DEPTH);

   // Stage 1 registers
   logic                s1Valid;
   logic [WIDTH-1:0]    s1PcPlus4;
   logic [OFFSET_W-1:0] s1Offset;
   logic [WIDTH-1:0]    s1Rs;
   logic [WIDTH-1:0]    s1Rt;
   logic [2:0]          s1Op;
   logic                s1Pred;
   logic [IDX_W-1:0]    s1Idx;

   // Handshake / control
   logic s2Free;
   logic accept;
   logic xfer;

   // Predictor interface
   logic [IDX_W-1:0] rdIdx;
   logic             rdTaken;
   logic             phtWrEn;

   // Stage 1 evaluation
   logic [WIDTH-1:0] offShift;
   logic [WIDTH-1:0] targetC;
   logic             takenC;
   logic             illegalC;
   logic             rsNeg;
   logic             rsZero;

   assign s2Free   = !out_valid || out_ready;
   assign in_ready = !s1Valid || s2Free;
   assign accept   = in_valid && in_ready;
   assign xfer     = s1Valid && s2Free;

   // Word-aligned PCs: bits [1:0] carry no information, index from bit 2.
   assign rdIdx   = pc_plus4[IDX_W+1:2];
   assign phtWrEn = xfer && !illegalC;

   branch_pht #(
      .DEPTH (PHT_DEPTH),
      .IDX_W (IDX_W)
   ) u_pht (
      .clk     (clk),
      .rst_n   (rst_n),
      .rdIdx   (rdIdx),
      .rdTaken (rdTaken),
      .wrEn    (phtWrEn),
      .wrIdx   (s1Idx),
      .wrTaken (takenC)
   );

   // S1 occupancy: a new accept wins over the drain, which keeps it full.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1Valid <= 1'b0;
      end else if (accept) begin
         s1Valid <= 1'b1;
      end else if (xfer) begin
         s1Valid <= 1'b0;
      end
   end

   // S1 payload only matters while s1Valid, so it needs no reset.
   always_ff @(posedge clk) begin
      if (accept) begin
         s1PcPlus4 <= pc_plus4;
         s1Offset  <= offset;
         s1Rs      <= rs_val;
         s1Rt      <= rt_val;
         s1Op      <= br_op;
         s1Pred    <= rdTaken;
         s1Idx     <= rdIdx;
      end
   end

   // Sign-extended offset already shifted left by two.
   if (OFFSET_W == WIDTH - 2) begin : g_shiftExact
      assign offShift = {s1Offset, 2'b00};
   end else begin : g_shiftExt
      assign offShift = {{(WIDTH-OFFSET_W-2){s1Offset[OFFSET_W-1]}}, s1Offset, 2'b00};
   end

   // Truncating add: wrap-around past 2^WIDTH is intentional.
   assign targetC = s1PcPlus4 + offShift;

   assign rsNeg  = s1Rs[WIDTH-1];
   assign rsZero = (s1Rs == '0);

   always_comb begin
      takenC   = 1'b0;
      illegalC = 1'b0;
      case (s1Op)
         BR_BEQ:  takenC = (s1Rs == s1Rt);
         BR_BNE:  takenC = (s1Rs != s1Rt);
         BR_BLEZ: takenC = rsNeg || rsZero;
         BR_BGTZ: takenC = !rsNeg && !rsZero;
         BR_BLTZ: takenC = rsNeg;
         BR_BGEZ: takenC = !rsNeg;
         default: illegalC = 1'b1;
      endcase
   end

   // S2 / output register: data changes only on a transfer, so a stalled
   // result stays stable; draining clears only out_valid.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         taken      <= 1'b0;
         target     <= '0;
         next_pc    <= '0;
         pred_taken <= 1'b0;
         mispredict <= 1'b0;
         illegal    <= 1'b0;
      end else if (xfer) begin
         out_valid  <= 1'b1;
         taken      <= takenC;
         target     <= targetC;
         next_pc    <= takenC ? targetC : s1PcPlus4;
         pred_taken <= s1Pred;
         mispredict <= (s1Pred != takenC);
         illegal    <= illegalC;
      end else if (out_ready) begin
         out_valid  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// tb_branch_resolve_unit
// Scoreboard bench: the driver presents branches and, on every accept, a
// reference model pushes the expected result into exp_q; an independent
// monitor compares the DUT outputs against the queue head whenever out_valid
// is high (every stalled cycle too) and pops on out_ready.
// -----------------------------------------------------------------------------
module tb_branch_resolve_unit;

   localparam int WIDTH     = 32;
   localparam int OFFSET_W  = 16;
   localparam int PHT_DEPTH = 16;
   localparam int EXP_W     = 2*WIDTH + 4;

   logic                clk;
   logic                rst_n;
   logic                in_valid;
   logic                in_ready;
   logic [WIDTH-1:0]    pc_plus4;
   logic [OFFSET_W-1:0] offset;
   logic [WIDTH-1:0]    rs_val;
   logic [WIDTH-1:0]    rt_val;
   logic [2:0]          br_op;
   logic                out_valid;
   logic                out_ready;
   logic                taken;
   logic [WIDTH-1:0]    target;
   logic [WIDTH-1:0]    next_pc;
   logic                pred_taken;
   logic                mispredict;
   logic                illegal;

   branch_resolve_unit #(
      .WIDTH     (WIDTH),
      .OFFSET_W  (OFFSET_W),
      .PHT_DEPTH (PHT_DEPTH)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .pc_plus4   (pc_plus4),
      .offset     (offset),
      .rs_val     (rs_val),
      .rt_val     (rt_val),
      .br_op      (br_op),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .taken      (taken),
      .target     (target),
      .next_pc    (next_pc),
      .pred_taken (pred_taken),
      .mispredict (mispredict),
      .illegal    (illegal)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- scoreboard state ----------------
   logic [EXP_W-1:0] exp_q[$];
   int vectors     = 0;
   int miscompares = 0;

   // Reference model: counters as plain integers 0..3, plus the most recent
   // legal branch whose counter step has not been folded in yet.
   int mPht [PHT_DEPTH];
   bit pendValid;
   int pendIdx;
   bit pendTaken;
   int occ;        // branches inside the unit during the current cycle
   int cycle;
   int lastAcc;    // cycle of the most recent accept

   function automatic logic [EXP_W-1:0] packRes(input bit il, input bit mis, input bit pr,
                                                input bit tk, input logic [WIDTH-1:0] np,
                                                input logic [WIDTH-1:0] tg);
      return {il, mis, pr, tk, np, tg};
   endfunction

   task automatic check(input string name, input logic [EXP_W-1:0] act, input logic [EXP_W-1:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic failNow(input string name);
      vectors++;
      miscompares++;
      $display("FAIL %s: bound expired with %0d results outstanding (t=%0t)", name, exp_q.size(), $time);
   endtask

   task automatic applyPending();
      if (pendValid) begin
         if (pendTaken && mPht[pendIdx] < 3) mPht[pendIdx]++;
         else if (!pendTaken && mPht[pendIdx] > 0) mPht[pendIdx]--;
         pendValid = 0;
      end
   endtask

   task automatic modelReset();
      foreach (mPht[i]) mPht[i] = 1;
      pendValid = 0;
      occ       = 0;
      lastAcc   = -10;
      exp_q.delete();
   endtask

   // Called for a branch accepted at the upcoming edge. The previous branch's
   // counter step is invisible to this read exactly when that branch is still
   // waiting in the first stage at this edge (no bypass).
   task automatic modelAccept();
      int idx;
      bit stale, tk, il, pr;
      int so;
      logic [WIDTH-1:0] tgt, np;
      idx   = int'((pc_plus4 >> 2) % PHT_DEPTH);
      stale = (occ == 2) || (occ == 1 && lastAcc == cycle - 1);
      if (!stale) applyPending();
      pr = (mPht[idx] >= 2);
      applyPending();
      so  = int'($signed(offset));
      tgt = pc_plus4 + 32'(so * 4);
      tk  = 0;
      il  = 0;
      case (br_op)
         3'd0: tk = (rs_val == rt_val);
         3'd1: tk = (rs_val != rt_val);
         3'd2: tk = ($signed(rs_val) <= 0);
         3'd3: tk = ($signed(rs_val) > 0);
         3'd4: tk = ($signed(rs_val) < 0);
         3'd5: tk = ($signed(rs_val) >= 0);
         default: il = 1;
      endcase
      np = tk ? tgt : pc_plus4;
      exp_q.push_back(packRes(il, pr != tk, pr, tk, np, tgt));
      if (!il) begin
         pendValid = 1;
         pendIdx   = idx;
         pendTaken = tk;
      end
      lastAcc = cycle;
   endtask

   // ---------------- driver tasks ----------------
   // Entered at a falling edge with inputs already set; returns at the next one.
   task automatic tick(output bit acc);
      bit pop;
      #1;
      acc = in_valid && in_ready;
      pop = out_valid && out_ready;
      if (acc) modelAccept();
      occ = occ + int'(acc) - int'(pop);
      cycle++;
      @(negedge clk);
   endtask

   task automatic present(input logic [2:0] op, input logic [WIDTH-1:0] pc,
                          input logic [OFFSET_W-1:0] off, input logic [WIDTH-1:0] rs,
                          input logic [WIDTH-1:0] rt);
      br_op    = op;
      pc_plus4 = pc;
      offset   = off;
      rs_val   = rs;
      rt_val   = rt;
      in_valid = 1'b1;
   endtask

   task automatic presentRandom();
      case ($urandom_range(0, 3))
         0: rs_val = '0;
         1: rs_val = 32'hFFFF_FFFF;
         2: rs_val = 32'($urandom);
         default: rs_val = 32'd1;
      endcase
      rt_val   = ($urandom_range(0, 1) == 1) ? rs_val : 32'($urandom);
      pc_plus4 = ($urandom_range(0, 7) == 0) ? (32'($urandom) & 32'hFFFF_FFFC)
                                             : 32'h1000 + 32'($urandom_range(0, 5)) * 4;
      offset   = 16'($urandom);
      br_op    = 3'($urandom_range(0, 7));
   endtask

   task automatic drain();
      int n;
      bit acc;
      n = 0;
      in_valid = 1'b0;
      while (exp_q.size() != 0 && n < 50) begin
         tick(acc);
         n++;
      end
      if (exp_q.size() != 0) failNow("drain_timeout");
   endtask

   task automatic sendAndWait(input logic [2:0] op, input logic [WIDTH-1:0] pc,
                              input logic [OFFSET_W-1:0] off, input logic [WIDTH-1:0] rs,
                              input logic [WIDTH-1:0] rt);
      bit acc;
      int n;
      acc = 0;
      n   = 0;
      present(op, pc, off, rs, rt);
      while (!acc && n < 20) begin
         tick(acc);
         n++;
      end
      in_valid = 1'b0;
      if (!acc) failNow("accept_timeout");
      drain();
   endtask

   // Entered at a falling edge; holds reset over two rising edges, releases,
   // and checks the post-reset state. Returns 1 time unit after a falling edge.
   task automatic doReset();
      rst_n    = 1'b0;
      in_valid = 1'b0;
      modelReset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rst_out_valid", EXP_W'(out_valid), EXP_W'(1'b0));
      check("rst_in_ready", EXP_W'(in_ready), EXP_W'(1'b1));
      check("rst_outputs", packRes(illegal, mispredict, pred_taken, taken, next_pc, target), '0);
   endtask

   // ---------------- monitor ----------------
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_output: got next_pc=%h with no branch outstanding", next_pc);
            end else begin
               check("result", packRes(illegal, mispredict, pred_taken, taken, next_pc, target), exp_q[0]);
               if (out_ready) void'(exp_q.pop_front());
            end
         end
      end
   end

   // ---------------- main stimulus ----------------
   initial begin
      bit acc;
      int accCnt;
      int n;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      pc_plus4  = '0;
      offset    = '0;
      rs_val    = '0;
      rt_val    = '0;
      br_op     = '0;
      cycle     = 0;
      @(negedge clk);
      doReset();

      // Not-taken BEQ straight after reset.
      sendAndWait(3'd0, 32'd100, 16'd4, 32'd15, 32'd10);

      // Taken BEQ three times at one PC, then a not-taken and an illegal op
      // at the same PC: saturation and the illegal no-update are visible in
      // the following predictions.
      doReset();
      sendAndWait(3'd0, 32'd100, 16'd4, 32'd10, 32'd10);
      sendAndWait(3'd0, 32'd100, 16'd4, 32'd10, 32'd10);
      sendAndWait(3'd0, 32'd100, 16'd4, 32'd10, 32'd10);
      sendAndWait(3'd1, 32'd100, 16'd4, 32'd7, 32'd7);
      sendAndWait(3'd7, 32'd100, 16'd4, 32'd7, 32'd7);
      sendAndWait(3'd0, 32'd100, 16'd4, 32'd3, 32'd3);

      // Negative offset, wrap-around target, signed compares.
      sendAndWait(3'd1, 32'd100, 16'hFFFE, 32'd1, 32'd2);
      sendAndWait(3'd4, 32'hFFFF_FFFC, 16'd1, 32'hFFFF_FFFF, 32'd0);
      sendAndWait(3'd3, 32'd300, 16'd8, 32'd0, 32'd0);
      sendAndWait(3'd2, 32'd300, 16'd8, 32'h8000_0000, 32'd0);
      sendAndWait(3'd5, 32'd304, 16'h8000, 32'd0, 32'd0);
      sendAndWait(3'd6, 32'd308, 16'd8, 32'd0, 32'd0);

      // Backpressure: four cycles of out_ready low with input held valid.
      out_ready = 1'b0;
      accCnt    = 0;
      present(3'd0, 32'd200, 16'd1, 32'd5, 32'd5);
      for (int c = 0; c < 4; c++) begin
         tick(acc);
         if (acc) begin
            accCnt++;
            present(3'($urandom_range(0, 5)), 32'd200 + 32'(accCnt) * 4, 16'd3, 32'(accCnt), 32'd5);
         end
      end
      #1;
      check("bp_accepts", EXP_W'(accCnt), EXP_W'(2));
      check("bp_in_ready", EXP_W'(in_ready), EXP_W'(1'b0));
      out_ready = 1'b1;
      acc = 0;
      n   = 0;
      while (!acc && n < 20) begin
         tick(acc);
         n++;
      end
      if (!acc) failNow("bp_release_accept");
      drain();

      // Reset with both stages full; the counter at PC 100 is back to weak.
      out_ready = 1'b0;
      accCnt    = 0;
      n         = 0;
      present(3'd0, 32'd100, 16'd4, 32'd10, 32'd10);
      while (accCnt < 2 && n < 20) begin
         tick(acc);
         if (acc) accCnt++;
         n++;
      end
      if (accCnt < 2) failNow("fill_timeout");
      doReset();
      out_ready = 1'b1;
      @(negedge clk);
      sendAndWait(3'd0, 32'd100, 16'd4, 32'd10, 32'd10);

      // Randomized traffic with random backpressure.
      for (int c = 0; c < 600; c++) begin
         if (!in_valid || acc) begin
            in_valid = ($urandom_range(0, 9) < 7);
            presentRandom();
         end
         out_ready = ($urandom_range(0, 9) < 7);
         tick(acc);
      end
      out_ready = 1'b1;
      n = 0;
      while (in_valid && !acc && n < 20) begin
         tick(acc);
         n++;
      end
      if (in_valid && !acc) failNow("final_accept");
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Parametrised, pipelined branch resolution unit for the single-cycle-to-pipelined MIPS datapath. It accepts a branch (PC+4, 16-bit offset, two register operands, branch opcode) over a valid/ready handshake and computes the branch target by sign-extend, shift-left-2 and add. It evaluates one of six MIPS branch conditions and returns the resolved next PC. A table of 2-bit saturating counters supplies a prediction per branch and flags mispredicts for the fetch stage.

## Interface
- `WIDTH`, 32: datapath width (PC and operands).
- `OFFSET_W`, 16: immediate offset width; must be ≤ WIDTH-2.
- `PHT_DEPTH`, 16: predictor counters; power of 2, ≥ 2.
- `clk`  in  1  sole clock; all state changes on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `in_valid`  in  1  branch presented.
- `in_ready`  out  1  unit can accept.
- `pc_plus4`  in  WIDTH  address of the branch + 4.
- `offset`  in  OFFSET_W  signed word offset.
- `rs_val`, `rt_val`  in  WIDTH  register operands.
- `br_op`  in  3  opcode: 0 BEQ, 1 BNE, 2 BLEZ, 3 BGTZ, 4 BLTZ, 5 BGEZ, 6–7 illegal.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer accepts result.
- `taken`  out  1  resolved outcome.
- `target`  out  WIDTH  computed branch address.
- `next_pc`  out  WIDTH  `taken ? target : pc_plus4`.
- `pred_taken`  out  1  prediction read for this branch.
- `mispredict`  out  1  `pred_taken != taken`.
- `illegal`  out  1  br_op was 6 or 7.

## Operation
- Two register stages: S1 (captured inputs + prediction) and S2 (output register).
- Accept when `in_valid && in_ready`: inputs latched into S1, counter `pht[idx]` read; `idx = pc_plus4[log2(PHT_DEPTH)+1:2]`.
- S1→S2 transfer when S1 valid and S2 free (`!out_valid || out_ready`).
- `in_ready = !s1_valid || s2_free`. This is full throughput; there is no combinational path from `in_valid` to `in_ready`.
- Target is `pc_plus4 + (sext(offset) << 2)`, truncated to WIDTH. Wrap-around modulo 2^WIDTH is allowed and not flagged.
- Conditions:
  - BEQ: rs==rt. BNE: rs!=rt.
  - BLEZ/BGTZ/BLTZ/BGEZ: signed compare of rs against 0; rt ignored.
- Illegal opcode: taken=0, illegal=1, no counter update. The prediction is still reported, and mispredict is computed normally.
- Counter update on S1→S2 transfer (legal ops only): saturating increment if taken, saturating decrement if not.
- Counter reset value 2'b01 (weakly not-taken). `pred_taken = ctr[1]`.
- Read/write same index in the same cycle: the read returns the pre-update value. There is no bypass.
- A result is held stable on all outputs while `out_valid && !out_ready`.

## Timing
- Latency: accepted at edge E → `out_valid` high after edge E+1, if S2 is free.
- Back-to-back accepts are sustained when `out_ready` is held high.
- Reset (`rst_n` low at an edge):
  - S1/S2 valid cleared, `out_valid`=0.
  - `taken`, `pred_taken`, `mispredict`, `illegal` = 0; `target`, `next_pc` = 0.
  - All counters = 2'b01.
  - `in_ready` = 1 on the first cycle after reset.
- Reset mid-operation: in-flight branches are discarded with no counter update; the held output is dropped.
- Backpressure: with `out_ready` low, at most 2 branches are held (S2, S1), then `in_ready`=0.
- Simultaneous accept and drain in the same cycle is legal; no bubble is inserted.

## Structure
- Package `branch_pkg`: `br_op` encodings (`BR_BEQ`…`BR_BGEZ`), counter reset constant `PHT_INIT = 2'b01`.
- Sub-module `branch_pht`: PHT_DEPTH×2-bit saturating counter array. It has a synchronous-reset, combinational read port and one write port (index, taken, enable).
- Target arithmetic stays inline; the existing SignExtend/ShiftLeft2/Adder32 blocks are 16/32-bit fixed and not reused.

## Test plan
- BEQ, rs=15, rt=10, pc_plus4=100, offset=4, after reset → taken=0, next_pc=100, target=116, pred_taken=0, mispredict=0.
- BEQ rs=rt=10, same PC, sent three times:
  - 1st: taken=1, next_pc=116, mispredict=1.
  - 2nd: pred_taken=1, mispredict=0.
  - Counter saturates at 2'b11.
- offset=16'hFFFE, pc_plus4=100, BNE rs=1, rt=2 → target=92, taken=1.
- Signed compares:
  - pc_plus4=32'hFFFF_FFFC, offset=1, BLTZ rs=32'hFFFF_FFFF → taken=1, target=0 (wrap).
  - BGTZ rs=0 → taken=0.
  - br_op=7 → illegal=1, taken=0, counter unchanged.
- Backpressure: out_ready=0 for 4 cycles while in_valid is held → two accepts, then in_ready=0. Outputs are stable; on release, results drain in order, one per cycle.
- Reset mid-flight: rst_n low with both stages valid → next cycle out_valid=0, in_ready=1. A subsequent BEQ-taken at the same PC shows pred_taken=0.
